// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: bus widths, RV32I opcodes and the bubble instruction.
package id_stage_pkg;

    localparam int XLEN          = 32;
    localparam int INST_DATA_BUS = 32;
    localparam int INST_ADDR_BUS = 32;
    localparam int REG_ADDR_BUS  = 5;

    localparam logic [INST_DATA_BUS-1:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // True for every base RV32I major opcode
    function automatic logic opc_legal(input logic [6:0] opc);
        return (opc == OPC_LUI)   || (opc == OPC_AUIPC)  || (opc == OPC_JAL)   ||
               (opc == OPC_JALR)  || (opc == OPC_BRANCH) || (opc == OPC_LOAD)  ||
               (opc == OPC_STORE) || (opc == OPC_OPIMM)  || (opc == OPC_OP)    ||
               (opc == OPC_FENCE) || (opc == OPC_SYSTEM);
    endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: sign-extended RV32I immediate selected by instruction format.
module id_stage_imm_gen
    import id_stage_pkg::*;
(
    input  logic [INST_DATA_BUS-1:0] ins_i,
    output logic [XLEN-1:0]          imm_o
);

    // Format is implied by the major opcode; R-type and unknown opcodes yield zero
    always_comb begin
        imm_o = '0;
        case (ins_i[6:0])
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FENCE, OPC_SYSTEM:
                imm_o = {{20{ins_i[31]}}, ins_i[31:20]};
            OPC_STORE:
                imm_o = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
            OPC_BRANCH:
                imm_o = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_o = {ins_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: field/immediate decode, regfile addressing, load-use hazard detection and ID/EX register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INST_DATA_BUS-1:0] ins_i,
    input  logic [INST_ADDR_BUS-1:0] ins_addr_i,
    input  logic                     jump_flag,
    input  logic                     ex_hold,
    output logic [REG_ADDR_BUS-1:0]  rs1_raddr,
    output logic [REG_ADDR_BUS-1:0]  rs2_raddr,
    input  logic [XLEN-1:0]          rs1_rdata,
    input  logic [XLEN-1:0]          rs2_rdata,
    output logic                     hold_flag_o,
    output logic                     ex_valid,
    output logic [INST_DATA_BUS-1:0] ex_ins,
    output logic [INST_ADDR_BUS-1:0] ex_ins_addr,
    output logic [XLEN-1:0]          ex_rs1_data,
    output logic [XLEN-1:0]          ex_rs2_data,
    output logic [XLEN-1:0]          ex_imm,
    output logic [REG_ADDR_BUS-1:0]  ex_rd,
    output logic                     ex_rd_we,
    output logic                     ex_is_load,
    output logic                     ex_illegal
);

    logic [6:0]              opc;
    logic [REG_ADDR_BUS-1:0] rd;
    logic [XLEN-1:0]         imm;
    logic                    legal, uses_rs1, uses_rs2, writes_rd, hazard;

    logic                     ex_valid_q, ex_rd_we_q, ex_is_load_q, ex_illegal_q;
    logic [INST_DATA_BUS-1:0] ex_ins_q;
    logic [INST_ADDR_BUS-1:0] ex_ins_addr_q;
    logic [XLEN-1:0]          ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
    logic [REG_ADDR_BUS-1:0]  ex_rd_q;

    assign opc       = ins_i[6:0];
    assign rd        = ins_i[11:7];
    assign rs1_raddr = ins_i[19:15];
    assign rs2_raddr = ins_i[24:20];

    id_stage_imm_gen u_imm_gen (
        .ins_i (ins_i),
        .imm_o (imm)
    );

    // Operand usage and write-back class per opcode
    always_comb begin
        legal     = opc_legal(opc);
        uses_rs1  = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
        uses_rs2  = (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
        writes_rd = (opc == OPC_LUI)  || (opc == OPC_AUIPC) || (opc == OPC_JAL)   ||
                    (opc == OPC_JALR) || (opc == OPC_LOAD)  || (opc == OPC_OPIMM) ||
                    (opc == OPC_OP)   || (opc == OPC_SYSTEM);
    end

    // A bubble in ID/EX has ex_valid_q low, so it can never look like a pending load
    assign hazard = ex_valid_q && ex_is_load_q && (ex_rd_q != '0) &&
                    ((uses_rs1 && (rs1_raddr == ex_rd_q)) || (uses_rs2 && (rs2_raddr == ex_rd_q)));

    // A flush lets fetch take the jump, so it suppresses the freeze request
    assign hold_flag_o = !rst && !jump_flag && (ex_hold || hazard);

    // ID/EX register: flush > downstream hold > load-use bubble > capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst || jump_flag || (!ex_hold && hazard)) begin
            ex_valid_q    <= 1'b0;
            ex_ins_q      <= NOP_INST;
            ex_ins_addr_q <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_rd_we_q    <= 1'b0;
            ex_is_load_q  <= 1'b0;
            ex_illegal_q  <= 1'b0;
        end else if (!ex_hold) begin
            ex_valid_q    <= 1'b1;
            ex_ins_q      <= ins_i;
            ex_ins_addr_q <= ins_addr_i;
            ex_rs1_data_q <= rs1_rdata;
            ex_rs2_data_q <= rs2_rdata;
            ex_imm_q      <= imm;
            ex_rd_q       <= rd;
            ex_rd_we_q    <= legal && writes_rd && (rd != '0);
            ex_is_load_q  <= (opc == OPC_LOAD);
            ex_illegal_q  <= !legal;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_ins      = ex_ins_q;
    assign ex_ins_addr = ex_ins_addr_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rd_we    = ex_rd_we_q;
    assign ex_is_load  = ex_is_load_q;
    assign ex_illegal  = ex_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a fetch-like driver with a reference model pushes expectations,
// a monitor pops and compares combinational outputs mid-cycle and ID/EX state after each edge.
module tb_id_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] ins, pc, d1, d2, imm;
        logic [4:0]  rd;
        logic        we, ld, ill;
    } ex_t;

    typedef struct {
        logic       hold;
        logic [4:0] a1, a2;
        ex_t        cur;
        ex_t        nxt;
    } txn_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] ins_i = 32'h13, ins_addr_i = '0, rs1_rdata = '0, rs2_rdata = '0;
    logic        jump_flag = 1'b0, ex_hold = 1'b0;
    logic [4:0]  rs1_raddr, rs2_raddr, ex_rd;
    logic        hold_flag_o, ex_valid, ex_rd_we, ex_is_load, ex_illegal;
    logic [31:0] ex_ins, ex_ins_addr, ex_rs1_data, ex_rs2_data, ex_imm;

    id_stage dut (
        .clk(clk), .rst(rst), .ins_i(ins_i), .ins_addr_i(ins_addr_i),
        .jump_flag(jump_flag), .ex_hold(ex_hold),
        .rs1_raddr(rs1_raddr), .rs2_raddr(rs2_raddr),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .hold_flag_o(hold_flag_o), .ex_valid(ex_valid), .ex_ins(ex_ins),
        .ex_ins_addr(ex_ins_addr), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    int   total = 0, bad = 0;
    txn_t sb[$];
    ex_t  m;                    // model of ID/EX contents after the last edge
    logic [31:0] prog[$];       // instructions waiting in "fetch"
    logic [31:0] pc = 32'h100;

    localparam logic [6:0] OPS [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                         7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

    function automatic ex_t rst_val();
        ex_t r = '0;
        r.ins = 32'h13;
        return r;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] sh = $unsigned($signed(i) >>> 20);
        case (i[6:0])
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: return sh;
            7'h23: return (sh & 32'hFFFF_FFE0) | 32'(i[11:7]);
            7'h63: return (i[31] ? 32'hFFFF_F000 : 32'h0) + 32'(i[7]) * 2048 +
                          32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
            7'h37, 7'h17: return i & 32'hFFFF_F000;
            7'h6F: return (i[31] ? 32'hFFF0_0000 : 32'h0) + 32'(i[19:12]) * 4096 +
                          32'(i[20]) * 2048 + 32'(i[30:21]) * 2;
            default: return 32'h0;
        endcase
    endfunction

    function automatic ex_t ref_decode(input logic [31:0] i, p, d1, d2);
        ex_t e;
        logic [6:0] op = i[6:0];
        logic lg = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic wr = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h73};
        e.valid = 1'b1; e.ins = i; e.pc = p; e.d1 = d1; e.d2 = d2;
        e.imm = ref_imm(i); e.rd = i[11:7];
        e.we  = lg && wr && (i[11:7] != 0);
        e.ld  = (op == 7'h03);
        e.ill = !lg;
        return e;
    endfunction

    function automatic logic ref_hazard(input ex_t e, input logic [31:0] i);
        logic u1 = !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
        logic u2 = i[6:0] inside {7'h63, 7'h23, 7'h33};
        return e.valid && e.ld && (e.rd != 0) &&
               ((u1 && i[19:15] == e.rd) || (u2 && i[24:20] == e.rd));
    endfunction

    function automatic logic [31:0] rnd_ins();
        logic [31:0] i = $urandom;
        i[6:0]   = OPS[$urandom_range(11)];
        i[11:7]  = 5'($urandom_range(7));
        i[19:15] = 5'($urandom_range(7));
        i[24:20] = 5'($urandom_range(7));
        return i;
    endfunction

    // One cycle of stimulus: drive at the falling edge and push the expected response
    task automatic cyc(input logic r, input logic j, input logic h);
        txn_t t;
        logic hz;
        @(negedge clk);
        if (prog.size() == 0) prog.push_back(rnd_ins());
        rst = r; jump_flag = j; ex_hold = h;
        ins_i = prog[0]; ins_addr_i = pc;
        rs1_rdata = $urandom; rs2_rdata = $urandom;
        if (r) m = rst_val();
        t.cur = m;
        t.a1  = ins_i[19:15];
        t.a2  = ins_i[24:20];
        hz    = ref_hazard(m, ins_i);
        t.hold = !r && !j && (h || hz);
        if (r || j || (!h && hz)) t.nxt = rst_val();
        else if (h)               t.nxt = m;
        else                      t.nxt = ref_decode(ins_i, pc, rs1_rdata, rs2_rdata);
        m = t.nxt;
        if (!t.hold) begin
            void'(prog.pop_front());
            pc = j ? ($urandom & 32'hFFFF_FFFC) : pc + 4;
        end
        sb.push_back(t);
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ex_t dut_ex();
        return {ex_valid, ex_ins, ex_ins_addr, ex_rs1_data, ex_rs2_data, ex_imm,
                ex_rd, ex_rd_we, ex_is_load, ex_illegal};
    endfunction

    // Monitor: combinational outputs and current state mid-cycle, next state just after the edge
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                t = sb.pop_front();
                chk("hold_flag_o", hold_flag_o, t.hold);
                chk("rs1_raddr", rs1_raddr, t.a1);
                chk("rs2_raddr", rs2_raddr, t.a2);
                chk("ex_now", dut_ex(), t.cur);
                @(posedge clk);
                #1;
                chk("ex_next", dut_ex(), t.nxt);
            end
        end
    end

    initial begin
        m = rst_val();
        cyc(1, 0, 0); cyc(1, 0, 0);
        // addi x1,x0,-1 ; beq x0,x0,-4
        prog.push_back(32'hFFF0_0093); prog.push_back(32'hFE00_0EE3);
        cyc(0, 0, 0); cyc(0, 0, 0);
        // lw x5,0(x1) ; add x6,x5,x2 -> one-cycle stall
        prog.push_back(32'h0000_A283); prog.push_back(32'h0022_8333);
        repeat (4) cyc(0, 0, 0);
        // lw x0 ; add x6,x0,x0 -> no stall
        prog.push_back(32'h0000_2003); prog.push_back(32'h0000_0333);
        repeat (2) cyc(0, 0, 0);
        // flush while add is on ins_i
        prog.push_back(32'h0022_8333);
        cyc(0, 1, 0);
        // flush coinciding with a load-use hazard
        prog.push_back(32'h0000_A283); prog.push_back(32'h0022_8333);
        cyc(0, 0, 0); cyc(0, 1, 0);
        // downstream hold for three cycles, then release
        prog.push_back(32'h0041_81B3); prog.push_back(32'h0010_0513);
        cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 0);
        // illegal opcode
        prog.push_back(32'h0000_007F);
        cyc(0, 0, 0); cyc(0, 0, 0);
        // reset in the middle of the stream
        cyc(1, 0, 1); cyc(0, 0, 0);
        // randomized traffic
        repeat (800) begin
            int p = $urandom_range(99);
            cyc(p < 2, (p >= 2) && (p < 12), (p >= 12) && (p < 27));
        end
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
